// File: rtl/instruction_decoder_if.sv
// Instruction word in, decoded ARM-style fields out.
interface instruction_decoder_if;
  logic [31:0] instruccion;
  logic [3:0]  cond;
  logic [1:0]  op;
  logic        i;
  logic        uno;
  logic [3:0]  opcode;
  logic        p;
  logic        u;
  logic        b;
  logic        w;
  logic        s;
  logic        l1;
  logic        l2;
  logic [3:0]  rm;
  logic [3:0]  rn;
  logic [3:0]  rd;
  logic [11:0] operand2;
  logic [11:0] offset_std;
  logic [23:0] offset_branch;

  modport master (
    output instruccion,
    input  cond, op, i, uno, opcode, p, u, b, w, s, l1, l2,
           rm, rn, rd, operand2, offset_std, offset_branch
  );

  modport slave (
    input  instruccion,
    output cond, op, i, uno, opcode, p, u, b, w, s, l1, l2,
           rm, rn, rd, operand2, offset_std, offset_branch
  );
endinterface

// File: rtl/instruction_decoder.sv
// Registered field slicer for 32-bit ARM-style data-proc / memory / branch words.
module instruction_decoder (
  input  logic                  clk,
  input  logic                  rst,
  instruction_decoder_if.slave  bus
);

  typedef struct packed {
    logic [3:0]  cond;
    logic [1:0]  op;
    logic        imm;
    logic [3:0]  opcode;
    logic        s;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] low12;
    logic [23:0] offset_branch;
  } fields_t;

  fields_t w_fields;
  fields_t r_fields;

  // Slicing ignores op: the consumer picks the fields relevant to the format.
  always_comb begin
    w_fields               = '0;
    w_fields.cond          = bus.instruccion[31:28];
    w_fields.op            = bus.instruccion[27:26];
    w_fields.imm           = bus.instruccion[25];
    w_fields.opcode        = bus.instruccion[24:21];
    w_fields.s             = bus.instruccion[20];
    w_fields.rn            = bus.instruccion[19:16];
    w_fields.rd            = bus.instruccion[15:12];
    w_fields.low12         = bus.instruccion[11:0];
    w_fields.offset_branch = bus.instruccion[23:0];
  end

  always_ff @(posedge clk) begin
    if (rst) r_fields <= '0;
    else     r_fields <= w_fields;
  end

  // Aliased outputs share one flop each; opcode doubles as {p,u,b,w}.
  assign bus.cond          = r_fields.cond;
  assign bus.op            = r_fields.op;
  assign bus.i             = r_fields.imm;
  assign bus.uno           = r_fields.imm;
  assign bus.opcode        = r_fields.opcode;
  assign bus.p             = r_fields.opcode[3];
  assign bus.u             = r_fields.opcode[2];
  assign bus.b             = r_fields.opcode[1];
  assign bus.w             = r_fields.opcode[0];
  assign bus.l2            = r_fields.opcode[3];
  assign bus.s             = r_fields.s;
  assign bus.l1            = r_fields.s;
  assign bus.rn            = r_fields.rn;
  assign bus.rd            = r_fields.rd;
  assign bus.rm            = r_fields.low12[3:0];
  assign bus.operand2      = r_fields.low12;
  assign bus.offset_std    = r_fields.low12;
  assign bus.offset_branch = r_fields.offset_branch;

endmodule

// File: tb/tb_instruction_decoder.sv
// Randomized and directed checks of instruction_decoder against a shift/mask field model.
module tb_instruction_decoder;
  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  instruction_decoder_if bif();
  instruction_decoder dut (.clk(clk), .rst(rst), .bus(bif));

  always #5 clk = ~clk;

  localparam int VW = 79;

  function automatic int unsigned fld(input int unsigned x, input int lsb, input int width);
    return (x >> lsb) & ((32'd1 << width) - 1);
  endfunction

  // Expected output vector, in the same order as obs().
  function automatic logic [VW-1:0] model(input int unsigned x);
    return { 4'(fld(x,28,4)), 2'(fld(x,26,2)), 1'(fld(x,25,1)), 1'(fld(x,25,1)),
             4'(fld(x,21,4)), 1'(fld(x,24,1)), 1'(fld(x,23,1)), 1'(fld(x,22,1)),
             1'(fld(x,21,1)), 1'(fld(x,20,1)), 1'(fld(x,20,1)), 1'(fld(x,24,1)),
             4'(fld(x,0,4)), 4'(fld(x,16,4)), 4'(fld(x,12,4)),
             12'(fld(x,0,12)), 12'(fld(x,0,12)), 24'(fld(x,0,24)) };
  endfunction

  function automatic logic [VW-1:0] obs();
    return { bif.cond, bif.op, bif.i, bif.uno, bif.opcode, bif.p, bif.u, bif.b,
             bif.w, bif.s, bif.l1, bif.l2, bif.rm, bif.rn, bif.rd,
             bif.operand2, bif.offset_std, bif.offset_branch };
  endfunction

  task automatic cycle(input logic r, input logic [31:0] x);
    rst = r;
    bif.instruccion = x;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [VW-1:0] zero = '0;
    cycle(1'b1, 32'hFFFF_FFFF);
    cycle(1'b1, 32'hFFFF_FFFF);
    total++;
    if (obs() !== zero) $display("FAIL reset_all_zero got %h exp %h", obs(), zero);
    else passed++;
    cycle(1'b0, 32'hFFFF_FFFF);
    total++;
    if ({bif.cond, bif.op, bif.offset_branch} !== {4'hF, 2'd3, 24'hFF_FFFF})
      $display("FAIL reset_release got %h exp %h", {bif.cond, bif.op, bif.offset_branch},
               {4'hF, 2'd3, 24'hFF_FFFF});
    else passed++;
  endtask

  task automatic test_data_proc();
    cycle(1'b0, 32'hE047_5001);
    total++;
    if ({bif.cond, bif.op, bif.i, bif.opcode, bif.s, bif.rn, bif.rd, bif.operand2, bif.rm}
        !== {4'hE, 2'b00, 1'b0, 4'b0010, 1'b0, 4'd7, 4'd5, 12'h001, 4'd1})
      $display("FAIL data_proc got %h exp %h",
               {bif.cond, bif.op, bif.i, bif.opcode, bif.s, bif.rn, bif.rd, bif.operand2, bif.rm},
               {4'hE, 2'b00, 1'b0, 4'b0010, 1'b0, 4'd7, 4'd5, 12'h001, 4'd1});
    else passed++;
  endtask

  task automatic test_memory();
    cycle(1'b0, 32'hE594_9010);
    total++;
    if ({bif.cond, bif.op, bif.i, bif.p, bif.u, bif.b, bif.w, bif.l1, bif.rn, bif.rd, bif.offset_std}
        !== {4'hE, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 4'd9, 12'h010})
      $display("FAIL memory got %h exp %h",
               {bif.cond, bif.op, bif.i, bif.p, bif.u, bif.b, bif.w, bif.l1, bif.rn, bif.rd, bif.offset_std},
               {4'hE, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 4'd9, 12'h010});
    else passed++;
  endtask

  task automatic test_branch();
    cycle(1'b0, 32'hBA00_0003);
    total++;
    if ({bif.cond, bif.op, bif.uno, bif.l2, bif.offset_branch}
        !== {4'hB, 2'b10, 1'b1, 1'b0, 24'h00_0003})
      $display("FAIL branch got %h exp %h", {bif.cond, bif.op, bif.uno, bif.l2, bif.offset_branch},
               {4'hB, 2'b10, 1'b1, 1'b0, 24'h00_0003});
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] vec [3] = '{32'hE047_5001, 32'hE594_9010, 32'hBA00_0003};
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, vec[k]);
      total++;
      if (obs() !== model(vec[k])) $display("FAIL back_to_back[%0d] got %h exp %h", k, obs(), model(vec[k]));
      else passed++;
    end
  endtask

  task automatic test_reset_midstream();
    logic [VW-1:0] zero = '0;
    cycle(1'b0, 32'hE594_9010);
    cycle(1'b1, 32'hBA00_0003);
    total++;
    if (obs() !== zero) $display("FAIL midstream_reset got %h exp %h", obs(), zero);
    else passed++;
    cycle(1'b0, 32'hE047_5001);
    total++;
    if (obs() !== model(32'hE047_5001))
      $display("FAIL midstream_resume got %h exp %h", obs(), model(32'hE047_5001));
    else passed++;
  endtask

  task automatic test_random();
    logic [VW-1:0] exp_v;
    logic [31:0]   x;
    logic          r;
    for (int k = 0; k < 300; k++) begin
      x = $urandom;
      r = ($urandom_range(0, 9) == 0);
      exp_v = r ? '0 : model(x);
      cycle(r, x);
      total++;
      if (obs() !== exp_v) $display("FAIL random[%0d] in %h rst %0b got %h exp %h", k, x, r, obs(), exp_v);
      else passed++;
      // Outputs must hold with no edge even if the input changes.
      bif.instruccion = ~x;
      #2;
      total++;
      if (obs() !== exp_v) $display("FAIL hold[%0d] got %h exp %h", k, obs(), exp_v);
      else passed++;
    end
  endtask

  initial begin
    rst = 1'b1;
    bif.instruccion = '0;
    test_reset();
    test_data_proc();
    test_memory();
    test_branch();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
